// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, except_type
// encodings and Status/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c
  } exc_code_e;

  typedef enum logic [31:0] {
    EXCT_NONE = 32'h0000_0000,
    EXCT_INT  = 32'h0000_0001,
    EXCT_ADEL = 32'h0000_0004,
    EXCT_ADES = 32'h0000_0005,
    EXCT_SYS  = 32'h0000_0008,
    EXCT_BP   = 32'h0000_0009,
    EXCT_RI   = 32'h0000_000a,
    EXCT_OV   = 32'h0000_000c,
    EXCT_ERET = 32'h0000_000e
  } exc_type_e;

  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 8;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_TI     = 30;
  localparam int unsigned CAUSE_BD     = 31;

  function automatic exc_code_e exc_code_of(input exc_type_e t);
    case (t)
      EXCT_ADEL: return EXC_ADEL;
      EXCT_ADES: return EXC_ADES;
      EXCT_SYS:  return EXC_SYS;
      EXCT_BP:   return EXC_BP;
      EXCT_RI:   return EXC_RI;
      EXCT_OV:   return EXC_OV;
      default:   return EXC_INT;
    endcase
  endfunction

endpackage

// File: rtl/cp0_exception_unit_if.sv
// M-stage exception flags, mtc0/mfc0 access and flush/redirect results.
interface cp0_exception_unit_if;
  logic        m_valid;
  logic        m_stall;
  logic        ri, brk, syscall, overflow;
  logic        addr_err_lw, addr_err_sw, pc_error, eret;
  logic        in_delay_slot;
  logic [31:0] pc_m;
  logic [31:0] alu_out_m;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic [31:0] except_type;
  logic        flush_exception;
  logic [31:0] pc_exception;

  modport master (
    output m_valid, m_stall, ri, brk, syscall, overflow, addr_err_lw, addr_err_sw,
           pc_error, eret, in_delay_slot, pc_m, alu_out_m,
           cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    input  cp0_rdata, except_type, flush_exception, pc_exception
  );

  modport slave (
    input  m_valid, m_stall, ri, brk, syscall, overflow, addr_err_lw, addr_err_sw,
           pc_error, eret, in_delay_slot, pc_m, alu_out_m,
           cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    output cp0_rdata, except_type, flush_exception, pc_exception
  );
endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with prescaler and sticky timer interrupt.
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic          count_upd;
  logic [31:0]   count_next;

  always_comb begin
    tick       = (presc == PW'(COUNT_DIV - 1));
    count_upd  = count_we | tick;
    count_next = count_we ? wdata : count + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      presc <= (count_we || tick) ? '0 : presc + PW'(1);
      if (count_upd) count <= count_next;
      if (compare_we) compare <= wdata;
      // Match fires only when Count takes a new value, so the all-zero
      // post-reset state does not raise TI; a Compare write always wins.
      if (compare_we) ti <= 1'b0;
      else if (count_upd && count_next == compare) ti <= 1'b1;
    end
  end
endmodule

// File: rtl/cp0_exception_unit.sv
// M-stage exception resolver with the CP0 Status/Cause/EPC/BadVAddr state
// it commits into, plus mtc0/mfc0 access and the Count/Compare timer.
module cp0_exception_unit
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_EXT_INT  = 6,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned COUNT_DIV    = 2,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_EXT_INT-1:0] ext_int,
  cp0_exception_unit_if.slave    pipe,
  output logic [31:0]            status_o,
  output logic [31:0]            cause_o,
  output logic [31:0]            epc_o,
  output logic                   timer_int_o
);
  logic [31:0] status, epc, badvaddr, count, compare, cause;
  logic [5:0]  hw_ip, ext_pad;
  logic [1:0]  sw_ip;
  logic        bd, ti, int_req, commit, mtc0;
  logic [4:0]  exc_code;
  logic [7:0]  ip;
  exc_type_e   etype;

  always_comb begin
    ext_pad = '0;
    ext_pad[NUM_EXT_INT-1:0] = ext_int;
  end

  always_comb begin
    ip = {hw_ip[5] | ti, hw_ip[4:0], sw_ip};
    cause = '0;
    cause[CAUSE_BD] = bd;
    cause[CAUSE_TI] = ti;
    cause[CAUSE_IP_LO +: 8] = ip;
    cause[CAUSE_EXC_LO +: 5] = exc_code;
    int_req = status[STATUS_IE] & ~status[STATUS_EXL] & |(status[STATUS_IM_LO +: 8] & ip);
  end

  always_comb begin
    etype = EXCT_NONE;
    if (pipe.m_valid) begin
      if (int_req)                                etype = EXCT_INT;
      else if (pipe.addr_err_lw || pipe.pc_error) etype = EXCT_ADEL;
      else if (pipe.ri)                           etype = EXCT_RI;
      else if (pipe.syscall)                      etype = EXCT_SYS;
      else if (pipe.brk)                          etype = EXCT_BP;
      else if (pipe.addr_err_sw)                  etype = EXCT_ADES;
      else if (pipe.overflow)                     etype = EXCT_OV;
      else if (pipe.eret)                         etype = EXCT_ERET;
    end
  end

  assign pipe.except_type     = etype;
  assign pipe.flush_exception = (etype != EXCT_NONE);
  assign pipe.pc_exception    = (etype == EXCT_NONE) ? '0 :
                                (etype == EXCT_ERET) ? epc : EXC_VECTOR;

  assign commit = (etype != EXCT_NONE) && !pipe.m_stall;
  assign mtc0   = pipe.cp0_we && !pipe.m_stall && (etype == EXCT_NONE);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc0 && pipe.cp0_waddr == CP0_COUNT),
    .compare_we (mtc0 && pipe.cp0_waddr == CP0_COMPARE),
    .wdata      (pipe.cp0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      status   <= STATUS_RESET;
      epc      <= '0;
      badvaddr <= '0;
      hw_ip    <= '0;
      sw_ip    <= '0;
      bd       <= 1'b0;
      exc_code <= '0;
    end else begin
      hw_ip <= ext_pad;
      if (commit) begin
        if (etype == EXCT_ERET) begin
          status[STATUS_EXL] <= 1'b0;
        end else begin
          // Nested exceptions keep the original EPC/BD for the outer handler.
          if (!status[STATUS_EXL]) begin
            epc <= pipe.in_delay_slot ? pipe.pc_m - 32'd4 : pipe.pc_m;
            bd  <= pipe.in_delay_slot;
          end
          exc_code           <= exc_code_of(etype);
          status[STATUS_EXL] <= 1'b1;
          if (etype == EXCT_ADEL || etype == EXCT_ADES)
            badvaddr <= pipe.pc_error ? pipe.pc_m : pipe.alu_out_m;
        end
      end else if (mtc0) begin
        case (pipe.cp0_waddr)
          CP0_STATUS: status <= (status & ~STATUS_WMASK) | (pipe.cp0_wdata & STATUS_WMASK);
          CP0_CAUSE:  sw_ip  <= pipe.cp0_wdata[9:8];
          CP0_EPC:    epc    <= pipe.cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (pipe.cp0_raddr)
      CP0_BADVADDR: pipe.cp0_rdata = badvaddr;
      CP0_COUNT:    pipe.cp0_rdata = count;
      CP0_COMPARE:  pipe.cp0_rdata = compare;
      CP0_STATUS:   pipe.cp0_rdata = status;
      CP0_CAUSE:    pipe.cp0_rdata = cause;
      CP0_EPC:      pipe.cp0_rdata = epc;
      default:      pipe.cp0_rdata = '0;
    endcase
  end

  assign status_o    = status;
  assign cause_o     = cause;
  assign epc_o       = epc;
  assign timer_int_o = ti;
endmodule

// File: tb/tb_cp0_exception_unit.sv
// Bench for cp0_exception_unit: priority table, directed corner sequences and
// a randomized run against a behavioural CP0 model.
module tb_cp0_exception_unit;
  import cp0_pkg::*;

  localparam int DIV = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ext_int;
  logic [31:0] status_o, cause_o, epc_o;
  logic        timer_int_o;

  cp0_exception_unit_if pipe();

  cp0_exception_unit #(
    .NUM_EXT_INT (6),
    .EXC_VECTOR  (VEC),
    .COUNT_DIV   (DIV),
    .STATUS_RESET(32'h0040_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ext_int    (ext_int),
    .pipe       (pipe),
    .status_o   (status_o),
    .cause_o    (cause_o),
    .epc_o      (epc_o),
    .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_status, m_epc, m_bad, m_count, m_compare;
  logic [5:0]  m_hwip;
  logic [1:0]  m_swip;
  logic        m_bd, m_ti;
  logic [4:0]  m_code;
  int          m_presc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_ip();
    return {m_hwip[5] | m_ti, m_hwip[4:0], m_swip};
  endfunction

  function automatic logic [31:0] m_cause();
    return ({31'b0, m_bd} << 31) | ({31'b0, m_ti} << 30) | ({24'b0, m_ip()} << 8) |
           ({27'b0, m_code} << 2);
  endfunction

  function automatic logic [31:0] m_type();
    logic        fl [7];
    logic [31:0] cd [7];
    if (!pipe.m_valid) return EXCT_NONE;
    if (m_status[0] && !m_status[1] && ((m_status[15:8] & m_ip()) != 8'h0)) return EXCT_INT;
    fl = '{pipe.addr_err_lw | pipe.pc_error, pipe.ri, pipe.syscall, pipe.brk,
           pipe.addr_err_sw, pipe.overflow, pipe.eret};
    cd = '{EXCT_ADEL, EXCT_RI, EXCT_SYS, EXCT_BP, EXCT_ADES, EXCT_OV, EXCT_ERET};
    for (int i = 0; i < 7; i++) if (fl[i]) return cd[i];
    return EXCT_NONE;
  endfunction

  function automatic logic [31:0] m_pc();
    logic [31:0] t;
    t = m_type();
    if (t == EXCT_NONE) return 32'h0;
    if (t == EXCT_ERET) return m_epc;
    return VEC;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_advance();
    logic [31:0] t, ncount;
    logic        commit, wr, cw, kw, upd;
    if (rst) begin
      m_status = 32'h0040_0000; m_epc = 0; m_bad = 0; m_count = 0; m_compare = 0;
      m_hwip = 0; m_swip = 0; m_bd = 0; m_ti = 0; m_code = 0; m_presc = 0;
      return;
    end
    t      = m_type();
    commit = (t != EXCT_NONE) && !pipe.m_stall;
    wr     = pipe.cp0_we && !pipe.m_stall && (t == EXCT_NONE);
    cw     = wr && pipe.cp0_waddr == 5'd9;
    kw     = wr && pipe.cp0_waddr == 5'd11;
    upd    = cw || (m_presc == DIV - 1);
    ncount = cw ? pipe.cp0_wdata : m_count + 1;
    m_presc = upd ? 0 : m_presc + 1;
    if (kw) m_ti = 0;
    else if (upd && ncount == m_compare) m_ti = 1;
    if (upd) m_count = ncount;
    if (kw) m_compare = pipe.cp0_wdata;
    if (commit) begin
      if (t == EXCT_ERET) m_status[1] = 0;
      else begin
        if (!m_status[1]) begin
          m_epc = pipe.in_delay_slot ? pipe.pc_m - 4 : pipe.pc_m;
          m_bd  = pipe.in_delay_slot;
        end
        case (t)
          EXCT_ADEL: m_code = 5'h04;
          EXCT_ADES: m_code = 5'h05;
          EXCT_SYS:  m_code = 5'h08;
          EXCT_BP:   m_code = 5'h09;
          EXCT_RI:   m_code = 5'h0a;
          EXCT_OV:   m_code = 5'h0c;
          default:   m_code = 5'h00;
        endcase
        m_status[1] = 1;
        if (t == EXCT_ADEL || t == EXCT_ADES) m_bad = pipe.pc_error ? pipe.pc_m : pipe.alu_out_m;
      end
    end else if (wr) begin
      case (pipe.cp0_waddr)
        5'd12: m_status = (m_status & ~32'h0000_FF03) | (pipe.cp0_wdata & 32'h0000_FF03);
        5'd13: m_swip = pipe.cp0_wdata[9:8];
        5'd14: m_epc = pipe.cp0_wdata;
        default: ;
      endcase
    end
    m_hwip = ext_int;
  endtask

  task automatic tick();
    m_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pipe.m_valid = 0; pipe.m_stall = 0; pipe.ri = 0; pipe.brk = 0; pipe.syscall = 0;
    pipe.overflow = 0; pipe.addr_err_lw = 0; pipe.addr_err_sw = 0; pipe.pc_error = 0;
    pipe.eret = 0; pipe.in_delay_slot = 0; pipe.pc_m = 0; pipe.alu_out_m = 0;
    pipe.cp0_we = 0; pipe.cp0_waddr = 0; pipe.cp0_wdata = 0; pipe.cp0_raddr = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    clr();
    pipe.cp0_we = 1; pipe.cp0_waddr = a; pipe.cp0_wdata = d;
    tick();
    pipe.cp0_we = 0;
  endtask

  typedef struct {
    logic        v, ri, brk, sys, ov, lw, sw, pce, er;
    logic [31:0] typ;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [10];
  logic [4:0] addrs [8];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, EXCT_NONE, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, EXCT_RI,   VEC};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, EXCT_ADEL, VEC};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, EXCT_ADEL, VEC};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, EXCT_SYS,  VEC};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, EXCT_BP,   VEC};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, EXCT_ADES, VEC};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, EXCT_OV,   VEC};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, EXCT_ERET, 32'h0};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, EXCT_NONE, 32'h0};
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};

    // Reset with all interrupt lines high
    clr(); rst = 1; ext_int = 6'h3F;
    tick(); tick();
    chk("rst_status", status_o, 32'h0040_0000);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_flush", {31'b0, pipe.flush_exception}, 32'h0);
    chk("rst_pcexc", pipe.pc_exception, 32'h0);
    rst = 0; ext_int = 0;
    tick();

    // Priority table, stalled so nothing commits
    for (int i = 0; i < 10; i++) begin
      clr(); pipe.m_stall = 1;
      pipe.m_valid = vecs[i].v; pipe.ri = vecs[i].ri; pipe.brk = vecs[i].brk;
      pipe.syscall = vecs[i].sys; pipe.overflow = vecs[i].ov; pipe.addr_err_lw = vecs[i].lw;
      pipe.addr_err_sw = vecs[i].sw; pipe.pc_error = vecs[i].pce; pipe.eret = vecs[i].er;
      #1;
      chk($sformatf("tbl%0d_type", i), pipe.except_type, vecs[i].typ);
      chk($sformatf("tbl%0d_pc", i), pipe.pc_exception, vecs[i].pc);
      chk($sformatf("tbl%0d_flush", i), {31'b0, pipe.flush_exception},
          {31'b0, vecs[i].typ != EXCT_NONE});
      tick();
    end
    chk("tbl_status_kept", status_o, 32'h0040_0000);
    chk("tbl_epc_kept", epc_o, 32'h0);

    // Interrupt after one-cycle sampling latency
    mtc0(5'd12, 32'h0000_FF01);
    chk("mtc0_status", status_o, 32'h0040_FF01);
    clr(); ext_int = 6'h04; pipe.m_valid = 1; pipe.pc_m = 32'h8000_0100;
    #1;
    chk("int_latency", pipe.except_type, EXCT_NONE);
    tick();
    chk("int_type", pipe.except_type, EXCT_INT);
    chk("int_pc", pipe.pc_exception, VEC);
    tick();
    chk("int_status", status_o, 32'h0040_FF03);
    chk("int_epc", epc_o, 32'h8000_0100);
    chk("int_cause", cause_o, 32'h0000_1000);
    ext_int = 0;
    mtc0(5'd12, 32'h0);
    chk("clr_status", status_o, 32'h0040_0000);

    // AdEL in a delay slot
    clr(); pipe.m_valid = 1; pipe.addr_err_lw = 1; pipe.in_delay_slot = 1;
    pipe.pc_m = 32'h8000_1004; pipe.alu_out_m = 32'h0000_0003;
    #1;
    chk("adel_type", pipe.except_type, EXCT_ADEL);
    tick();
    clr(); pipe.cp0_raddr = 5'd8;
    #1;
    chk("adel_badvaddr", pipe.cp0_rdata, 32'h0000_0003);
    chk("adel_epc", epc_o, 32'h8000_1000);
    chk("adel_cause", cause_o, 32'h8000_0010);
    chk("adel_status", status_o, 32'h0040_0002);

    // RI beats OV and suppresses a same-cycle mtc0; then eret
    clr(); pipe.m_valid = 1; pipe.ri = 1; pipe.overflow = 1;
    pipe.cp0_we = 1; pipe.cp0_waddr = 5'd14; pipe.cp0_wdata = 32'h1234_5678;
    #1;
    chk("ri_type", pipe.except_type, EXCT_RI);
    tick();
    clr();
    chk("ri_epc", epc_o, 32'h8000_1000);
    chk("ri_cause", cause_o, 32'h8000_0028);
    pipe.m_valid = 1; pipe.eret = 1;
    #1;
    chk("eret_type", pipe.except_type, EXCT_ERET);
    chk("eret_pc", pipe.pc_exception, 32'h8000_1000);
    tick();
    clr();
    chk("eret_status", status_o, 32'h0040_0000);
    chk("eret_cause", cause_o, 32'h8000_0028);

    // Timer: match six edges after Count=0 with Compare=3
    mtc0(5'd11, 32'd3);
    mtc0(5'd9, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) chk("ti_early", {31'b0, timer_int_o}, 32'h0);
      if (i == 6) begin
        chk("ti_set", {31'b0, timer_int_o}, 32'h1);
        chk("ti_cause", cause_o, 32'hC000_8028);
      end
    end
    mtc0(5'd11, 32'd3);
    chk("ti_cleared", {31'b0, timer_int_o}, 32'h0);
    mtc0(5'd9, 32'd0);
    for (int i = 1; i <= 5; i++) tick();
    mtc0(5'd11, 32'd3);
    chk("ti_cmp_wins", {31'b0, timer_int_o}, 32'h0);
    tick(); tick();
    chk("ti_stays_clear", {31'b0, timer_int_o}, 32'h0);
    chk("ti_cause_clear", cause_o, 32'h8000_0028);

    // Stalled syscall: flush asserted but no commit until release
    clr(); pipe.m_valid = 1; pipe.syscall = 1; pipe.m_stall = 1; pipe.pc_m = 32'h8000_2000;
    #1;
    chk("stall_flush", {31'b0, pipe.flush_exception}, 32'h1);
    chk("stall_type", pipe.except_type, EXCT_SYS);
    chk("stall_pc", pipe.pc_exception, VEC);
    tick();
    chk("stall_epc", epc_o, 32'h8000_1000);
    chk("stall_cause", cause_o, 32'h8000_0028);
    chk("stall_status", status_o, 32'h0040_0000);
    pipe.m_stall = 0;
    tick();
    clr();
    chk("sys_epc", epc_o, 32'h8000_2000);
    chk("sys_cause", cause_o, 32'h0000_0020);
    chk("sys_status", status_o, 32'h0040_0002);

    // Randomized run against the model
    rst = 1; tick(); rst = 0;
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      pipe.m_valid = ($urandom_range(0, 9) < 7);
      pipe.m_stall = ($urandom_range(0, 3) == 0);
      pipe.ri = ($urandom_range(0, 11) == 0);
      pipe.brk = ($urandom_range(0, 11) == 0);
      pipe.syscall = ($urandom_range(0, 11) == 0);
      pipe.overflow = ($urandom_range(0, 11) == 0);
      pipe.addr_err_lw = ($urandom_range(0, 11) == 0);
      pipe.addr_err_sw = ($urandom_range(0, 11) == 0);
      pipe.pc_error = ($urandom_range(0, 15) == 0);
      pipe.eret = ($urandom_range(0, 7) == 0);
      pipe.in_delay_slot = 1'($urandom_range(0, 1));
      pipe.pc_m = $urandom;
      pipe.alu_out_m = $urandom;
      if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom);
      pipe.cp0_we = ($urandom_range(0, 2) == 0);
      pipe.cp0_waddr = addrs[$urandom_range(0, 7)];
      pipe.cp0_wdata = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 15));
      pipe.cp0_raddr = addrs[$urandom_range(0, 7)];
      #1;
      chk("r_type", pipe.except_type, m_type());
      chk("r_flush", {31'b0, pipe.flush_exception}, {31'b0, m_type() != EXCT_NONE});
      chk("r_pc", pipe.pc_exception, m_pc());
      chk("r_rdata", pipe.cp0_rdata, m_read(pipe.cp0_raddr));
      chk("r_status", status_o, m_status);
      chk("r_cause", cause_o, m_cause());
      chk("r_epc", epc_o, m_epc);
      chk("r_ti", {31'b0, timer_int_o}, {31'b0, m_ti});
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
